sr_bank_ctrl: RTL
=================

Name: sr_bank_ctrl

Overview:
- Arbitrates set/clear/toggle requests from NREQ requesters onto a bank of NBITS SR flip-flops.
- Drives one-cycle S/R pulse vectors to the bank and reads its Q outputs back.
- Guarantees the bank never sees S=R=1 on any bit.
- Sits between software/control requesters and the sr_ff instances in the flag register bank.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR flip-flops in the bank (1..32)
- IDXW, $clog2(NBITS) (min 1), bit-index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid per requester
- req_op  in  2*NREQ  op per requester (packed, requester i at [2i+1:2i])
- req_idx  in  IDXW*NREQ  target bit index per requester (packed)
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready
- q_in  in  NBITS  Q outputs of the SR bank
- s_out  out  NBITS  set pulses to bank
- r_out  out  NBITS  reset pulses to bank
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse: accepted op had idx >= NBITS

Behaviour:
- Reset (rst=0, async):
  - s_out=0, r_out=0, done=0, err=0.
  - Round-robin pointer ptr=0; pending register cleared.
- Arbitration (combinational):
  - req_ready[i]=1 only for the first valid requester at or after ptr, scanning upward mod NREQ.
  - At most one bit is set; req_ready=0 when no request is valid.
  - req_ready is never asserted while rst=0.
- Pointer: on a transfer by requester w, ptr <= (w+1) mod NREQ. With no transfer, ptr holds.
- Ops (decoded at transfer, applied the next cycle):
  - OP_NOP: no pulse.
  - OP_SET: s_out[idx]=1.
  - OP_CLR: r_out[idx]=1.
  - OP_TGL: r_out[idx] if the current value is 1, else s_out[idx].
- Latency:
  - Transfer at edge E0 produces the s_out/r_out pulse and done[w] in the cycle after E0.
  - Each pulse is exactly one cycle wide; the bank captures it at edge E1.
- Exclusivity: one transfer per cycle, so at most one bit of s_out|r_out is high in any cycle. s_out & r_out is always 0.
- Toggle forwarding:
  - q_in is stale for the bit pulsed in the current cycle.
  - The pending register holds (valid, idx, new value) of the op being applied.
  - A TGL that matches the pending idx uses the pending value instead of q_in.
  - A pending NOP or an error does not forward.
- Out of range: for idx >= NBITS, no pulse is issued, err=1 and done[w]=1 in the same cycle as a normal op. Pending is not updated.
- Back-to-back: a requester holding valid high is re-granted only after all other valid requesters have been served (fairness bound NREQ cycles).
- Reset mid-operation: any in-flight pulse is cancelled immediately and the op is lost. Requesters must reissue after reset.

Decomposition:
- Package sr_ctrl_pkg:
  - Op encodings: OP_NOP=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_TGL=2'b11.
  - Helper function for IDXW.
- Sub-module rr_arbiter (NREQ): holds ptr, takes valid and transfer, outputs one-hot grant and winner index. Same clk/rst.
- Top level keeps the decode, pending/forwarding register and output registers.

Test Plan:
- Reset: hold rst=0 with all req_valid=1 -> req_ready=0, s_out=0, r_out=0, done=0, err=0. First grant after release goes to requester 0.
- Single set: req0 valid, op=SET, idx=3 -> req_ready=4'b0001 the same cycle; next cycle s_out=8'h08, r_out=0, done=4'b0001; then all zero.
- Round robin: all four valid with NOP, held for 8 cycles -> req_ready sequence 0001, 0010, 0100, 1000, 0001, …; done follows one cycle later; s_out=r_out=0 throughout.
- Toggle forwarding: q_in=0, req1 TGL idx=5 in two consecutive transfers (with req1 sole requester) -> s_out=8'h20, then r_out=8'h20 the next cycle, never both. A third TGL after q_in updates gives s_out=8'h20.
- Out of range (NBITS=6): req2 SET idx=7 -> s_out=r_out=0, err=1 and done=4'b0100 for exactly one cycle.
- Reset mid-op: drop rst during the s_out=8'h08 pulse -> s_out=0 immediately. After release, req3 and req0 valid -> req0 granted first (ptr=0).

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// ============================================================================
// Module  : sr_ctrl_pkg
// Purpose : Op encodings and width helper shared by the SR bank controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_CLR = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin arbiter; one-hot grant scanning upward from a pointer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid_i,
    input  logic            xfer_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   win_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          w_found;

    always_comb begin
        grant_o = '0;
        win_o   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && valid_i[(int'(ptr_q) + k) % NREQ]) begin
                grant_o[(int'(ptr_q) + k) % NREQ] = 1'b1;
                win_o   = PW'((int'(ptr_q) + k) % NREQ);
                w_found = 1'b1;
            end
        end
        // No grant may be visible while the block is held in reset.
        if (!rst) begin
            grant_o = '0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer_i) begin
            ptr_d = (win_o == PW'(NREQ - 1)) ? '0 : win_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sr_bank_ctrl.sv
// ============================================================================
// Module  : sr_bank_ctrl
// Purpose : Arbitrates set/clear/toggle requests onto a bank of SR flip-flops.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sr_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = idx_width(NBITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NBITS-1:0]     q_in,
    output logic [NBITS-1:0]     s_out,
    output logic [NBITS-1:0]     r_out,
    output logic [NREQ-1:0]      done,
    output logic                 err
);

    localparam int PW = idx_width(NREQ);

    logic [NREQ-1:0]  w_grant;
    logic [PW-1:0]    w_win;
    logic             w_xfer;
    op_e              w_op;
    logic [IDXW-1:0]  w_idx;
    logic [NBITS-1:0] w_bit;
    logic             w_in_range;
    logic             w_fwd;
    logic             w_cur;

    logic [NBITS-1:0] s_q, s_d;
    logic [NBITS-1:0] r_q, r_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             err_q, err_d;
    logic             pend_vld_q, pend_vld_d;
    logic [IDXW-1:0]  pend_idx_q, pend_idx_d;
    logic             pend_val_q, pend_val_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i (req_valid),
        .xfer_i  (w_xfer),
        .grant_o (w_grant),
        .win_o   (w_win)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);

    assign w_op       = op_e'(req_op[2*int'(w_win) +: 2]);
    assign w_idx      = req_idx[IDXW*int'(w_win) +: IDXW];
    assign w_bit      = NBITS'(1) << w_idx;
    assign w_in_range = ({1'b0, w_idx} < (IDXW+1)'(NBITS));

    // q_in lags the bit being pulsed this cycle, so take the in-flight value instead.
    assign w_fwd = pend_vld_q && (pend_idx_q == w_idx);
    assign w_cur = w_fwd ? pend_val_q : |(q_in & w_bit);

    always_comb begin
        s_d        = '0;
        r_d        = '0;
        done_d     = '0;
        err_d      = 1'b0;
        pend_vld_d = 1'b0;
        pend_idx_d = pend_idx_q;
        pend_val_d = pend_val_q;
        if (w_xfer) begin
            done_d = w_grant;
            if (!w_in_range) begin
                err_d = 1'b1;
            end else begin
                case (w_op)
                    OP_SET: begin
                        s_d        = w_bit;
                        pend_vld_d = 1'b1;
                        pend_idx_d = w_idx;
                        pend_val_d = 1'b1;
                    end
                    OP_CLR: begin
                        r_d        = w_bit;
                        pend_vld_d = 1'b1;
                        pend_idx_d = w_idx;
                        pend_val_d = 1'b0;
                    end
                    OP_TGL: begin
                        if (w_cur) begin
                            r_d = w_bit;
                        end else begin
                            s_d = w_bit;
                        end
                        pend_vld_d = 1'b1;
                        pend_idx_d = w_idx;
                        pend_val_d = ~w_cur;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q        <= '0;
            r_q        <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_val_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            pend_val_q <= pend_val_d;
        end
    end

    assign s_out = s_q;
    assign r_out = r_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

`default_nettype wire
